// File: rtl/inst_fetch_ctrl_pkg.sv
// rtl/inst_fetch_ctrl_pkg.sv - shared constants, FSM encoding and FIFO entry type for the fetch stage
package inst_fetch_ctrl_pkg;

    localparam int          PC_W          = 32;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] EXC_PC_DEF    = 32'h8000_0004;
    localparam logic [31:0] ROM_WORDS_DEF = 32'd512;
    localparam logic [31:0] NOP_INST      = 32'h0000_0000;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // 65-bit FIFO entry
    typedef struct packed {
        logic            fault;
        logic [PC_W-1:0] pc;
        logic [31:0]     inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// rtl/inst_fetch_ctrl_if.sv - ROM, redirect and decode-side signals of the fetch stage
// master: fetch controller (drives rom_addr and if_*)
// slave : surrounding core (drives rom_data, id_ready, redirect, redirect_pc, exc_req)
interface inst_fetch_ctrl_if;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        id_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        exc_req;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        if_fault;

    modport master (
        output rom_addr, if_valid, if_inst, if_pc, if_pc4, if_fault,
        input  rom_data, id_ready, redirect, redirect_pc, exc_req
    );

    modport slave (
        input  rom_addr, if_valid, if_inst, if_pc, if_pc4, if_fault,
        output rom_data, id_ready, redirect, redirect_pc, exc_req
    );
endinterface

// File: rtl/inst_fetch_ctrl_fetch_fifo2.sv
// rtl/inst_fetch_ctrl_fetch_fifo2.sv - 2-entry FIFO of {fault, pc, inst} between fetch and decode
// Ports: clk, reset (async active-low), enq/enq_data, deq, flush,
//        head/head_valid (zeroed when empty), count (0..2)
module fetch_fifo2
    import inst_fetch_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         enq,
    input  fetch_entry_t enq_data,
    input  logic         deq,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         head_valid,
    output logic [1:0]   count
);

    fetch_entry_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         enq_ok;
    logic         deq_ok;

    // A full FIFO only accepts when the head leaves in the same cycle.
    assign deq_ok = deq & (count != 2'd0);
    assign enq_ok = enq & ((count != 2'd2) | deq_ok);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (enq_ok) begin
                mem[wr_ptr] <= enq_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (deq_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({enq_ok, deq_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_valid = (count != 2'd0);
    assign head       = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - PC owner and fetch sequencer for the combinational instruction ROM
// Ports: clk, reset (async active-low), bus (inst_fetch_ctrl_if.master):
//        rom_addr/rom_data to the ROM, redirect/redirect_pc/exc_req from execute,
//        if_valid/if_inst/if_pc/if_pc4/if_fault with id_ready towards decode.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] EXC_PC    = EXC_PC_DEF,
    parameter logic [31:0] ROM_WORDS = ROM_WORDS_DEF
) (
    input  logic               clk,
    input  logic               reset,
    inst_fetch_ctrl_if.master  bus
);

    logic [PC_W-1:0] pc;
    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [1:0]      count;
    logic            head_valid;
    fetch_entry_t    head;
    fetch_entry_t    enq_data;
    logic            take;
    logic            fetch;
    logic            deq;
    logic            pc_fault;

    // A taken redirect kills this cycle's fetch and any handshake with decode.
    assign take  = bus.exc_req | bus.redirect;
    assign deq   = head_valid & bus.id_ready & ~take;
    assign fetch = (state == ST_FETCH) & ((count != 2'd2) | bus.id_ready) & ~take;

    // Bit 31 selects the kernel-segment alias of the same ROM, so the
    // exception vector lands on ROM word 1 rather than out of range.
    assign pc_fault = (pc[1:0] != 2'b00) || ({3'b000, pc[30:2]} >= ROM_WORDS);

    assign enq_data.fault = pc_fault;
    assign enq_data.pc    = pc;
    assign enq_data.inst  = pc_fault ? NOP_INST : bus.rom_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc    <= RESET_PC;
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
            if (bus.exc_req) begin
                pc <= EXC_PC;
            end else if (bus.redirect) begin
                pc <= bus.redirect_pc;
            end else if (fetch) begin
                pc <= pc + 32'd4;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (take) begin
            state_nxt = ST_FETCH;
        end else begin
            case (state)
                ST_BOOT:  state_nxt = ST_FETCH;
                ST_FETCH: if ((count == 2'd1) && fetch && !deq) state_nxt = ST_FULL;
                ST_FULL:  if (deq) state_nxt = ST_FETCH;
                default:  state_nxt = ST_FETCH;
            endcase
        end
    end

    fetch_fifo2 u_fifo (
        .clk        (clk),
        .reset      (reset),
        .enq        (fetch),
        .enq_data   (enq_data),
        .deq        (deq),
        .flush      (take),
        .head       (head),
        .head_valid (head_valid),
        .count      (count)
    );

    assign bus.rom_addr = pc;
    assign bus.if_valid = head_valid;
    assign bus.if_inst  = head.inst;
    assign bus.if_pc    = head.pc;
    assign bus.if_pc4   = head_valid ? head.pc + 32'd4 : 32'd0;
    assign bus.if_fault = head.fault;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb/tb_inst_fetch_ctrl.sv - scoreboard bench for inst_fetch_ctrl
module tb_inst_fetch_ctrl;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rom [512];
    exp_t        sb [$];
    int          chk_cnt  = 0;
    int          pass_cnt = 0;

    inst_fetch_ctrl_if bus ();

    inst_fetch_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.rom_data = rom[bus.rom_addr[10:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst, input logic fault);
        exp_t e;
        e.pc = pc; e.inst = inst; e.fault = fault;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            step();
            n++;
        end
        check({name, "_drained"}, 32'(sb.size()), 32'd0);
        bus.id_ready = 1'b0;
        sb.delete();
    endtask

    // Redirect (or exception) issued with decode stalled, then drained.
    task automatic redirect_drain(input string name, input logic [31:0] tgt,
                                  input logic exc, input logic [31:0] exp_addr);
        bus.redirect    = 1'b1;
        bus.redirect_pc = tgt;
        bus.exc_req     = exc;
        step();
        bus.redirect    = 1'b0;
        bus.exc_req     = 1'b0;
        check({name, "_rom_addr"}, bus.rom_addr, exp_addr);
        check({name, "_flushed"}, 32'(bus.if_valid), 32'd0);
        bus.id_ready = 1'b1;
        wait_drain(name);
    endtask

    // Monitor: every accepted head is compared against the next expectation.
    always @(negedge clk) begin
        if (reset && bus.if_valid && bus.id_ready && !bus.redirect && !bus.exc_req) begin
            if (sb.size() == 0) begin
                check("unexpected_handshake_pc", bus.if_pc, 32'hxxxx_xxxx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("if_pc", bus.if_pc, e.pc);
                check("if_inst", bus.if_inst, e.inst);
                check("if_fault", 32'(bus.if_fault), 32'(e.fault));
                check("if_pc4", bus.if_pc4, e.pc + 32'd4);
            end
        end
    end

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = 32'h2000_0000 | 32'(i);
        rom[0] = 32'h0800_0003;
        rom[1] = 32'h0800_0003;
        rom[2] = 32'h0800_0003;
        rom[3] = 32'h012a_4022;

        reset           = 1'b0;
        bus.id_ready    = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.exc_req     = 1'b0;
        repeat (3) step();
        check("rst_if_valid", 32'(bus.if_valid), 32'd0);
        check("rst_if_pc", bus.if_pc, 32'd0);
        check("rst_if_inst", bus.if_inst, 32'd0);
        check("rst_if_pc4", bus.if_pc4, 32'd0);
        check("rst_if_fault", 32'(bus.if_fault), 32'd0);
        check("rst_rom_addr", bus.rom_addr, 32'd0);

        // Sequential run
        push_exp(32'h00, 32'h0800_0003, 1'b0);
        push_exp(32'h04, 32'h0800_0003, 1'b0);
        push_exp(32'h08, 32'h0800_0003, 1'b0);
        push_exp(32'h0C, 32'h012a_4022, 1'b0);
        push_exp(32'h10, 32'h2000_0004, 1'b0);
        push_exp(32'h14, 32'h2000_0005, 1'b0);
        step();
        reset = 1'b1;
        step();
        check("boot_no_output", 32'(bus.if_valid), 32'd0);
        step();
        check("first_latency_valid", 32'(bus.if_valid), 32'd1);
        check("first_latency_pc", bus.if_pc, 32'd0);
        wait_drain("seq");

        // Async reset with a full FIFO
        repeat (3) step();
        check("full_before_reset", 32'(bus.if_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_if_valid", 32'(bus.if_valid), 32'd0);
        check("async_rst_rom_addr", bus.rom_addr, 32'd0);
        repeat (2) step();

        // Back-pressure from reset
        reset = 1'b1;
        repeat (3) step();
        for (int k = 0; k < 5; k++) begin
            check("bp_rom_addr", bus.rom_addr, 32'h8);
            check("bp_if_pc", bus.if_pc, 32'h0);
            step();
        end
        push_exp(32'h00, 32'h0800_0003, 1'b0);
        push_exp(32'h04, 32'h0800_0003, 1'b0);
        push_exp(32'h08, 32'h0800_0003, 1'b0);
        bus.id_ready = 1'b1;
        wait_drain("bp");

        // Redirect while rom_addr=8
        reset = 1'b0;
        repeat (2) step();
        push_exp(32'h00, 32'h0800_0003, 1'b0);
        push_exp(32'h18, 32'h2000_0006, 1'b0);
        push_exp(32'h1C, 32'h2000_0007, 1'b0);
        bus.id_ready = 1'b1;
        reset = 1'b1;
        begin
            int n = 0;
            while (bus.rom_addr != 32'h8 && n < 10) begin
                step();
                n++;
            end
        end
        check("rd_reach_8", bus.rom_addr, 32'h8);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h18;
        step();
        bus.redirect = 1'b0;
        check("rd_if_valid", 32'(bus.if_valid), 32'd0);
        check("rd_rom_addr", bus.rom_addr, 32'h18);
        step();
        check("rd_if_pc", bus.if_pc, 32'h18);
        wait_drain("rd");

        // Exception beats a simultaneous redirect
        push_exp(32'h8000_0004, 32'h0800_0003, 1'b0);
        push_exp(32'h8000_0008, 32'h0800_0003, 1'b0);
        redirect_drain("exc", 32'h30, 1'b1, 32'h8000_0004);

        // Misaligned and out-of-range fetches
        push_exp(32'h802, 32'h0, 1'b1);
        push_exp(32'h806, 32'h0, 1'b1);
        redirect_drain("mis", 32'h802, 1'b0, 32'h802);
        push_exp(32'h800, 32'h0, 1'b1);
        push_exp(32'h804, 32'h0, 1'b1);
        redirect_drain("oor", 32'h800, 1'b0, 32'h800);

        // PC wrap from the top of the address space
        push_exp(32'hFFFF_FFFC, 32'h0, 1'b1);
        push_exp(32'h0000_0000, 32'h0800_0003, 1'b0);
        redirect_drain("wrap", 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
